// File: rtl/vpu_pkg.sv
// Shared types and widths for the VPU host-side request path.
//   INSTR_WIDTH      encoded VPU instruction width
//   STREAM_ID_WIDTH  stream tag width
//   vpu_req_entry_t  one buffered command {instr, stream_id}
//   vpu_issue_state_t issuer FSM states
package vpu_pkg;

   localparam int INSTR_WIDTH     = 32;
   localparam int STREAM_ID_WIDTH = 3;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0]     instr;
      logic [STREAM_ID_WIDTH-1:0] stream_id;
   } vpu_req_entry_t;

   localparam int ENTRY_WIDTH = $bits(vpu_req_entry_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2
   } vpu_issue_state_t;

endpackage

// File: rtl/vpu_sync_fifo.sv
// Synchronous FIFO used as the issuer's command buffer.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_push, i_data     write request and data (ignored when full)
//   i_pop              read request (ignored when empty)
//   o_head             entry at the read pointer
//   o_next             entry behind the head, valid only when o_count > 1
//   o_count            occupancy, one bit wider than the pointers
//   o_full             occupancy equals DEPTH
module vpu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [WIDTH-1:0]         o_next,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && (r_count != '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   // Lets the issuer load the following request in the same cycle as a pop.
   assign o_next  = r_mem[r_rd_ptr + AW'(1)];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vpu_req_issuer.sv
// Host-side initiator for the VPU request/response protocol.
// Buffers commands, issues them as VPU requests, tracks in-flight stream IDs
// and retires them on matching responses. Stray responses set a sticky error.
// Build option: VPU_REQ_TIMEOUT_EN adds a response watchdog that also sets err_o.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake; ready = command FIFO not full
//   cmd_instr_i/cmd_stream_id_i  command payload
//   req_valid_o/req_ready_i   request handshake to the VPU
//   req_instr_o/req_stream_id_o  request payload, held stable until accepted
//   rsp_valid_i/rsp_ready_o   response input; always accepted
//   rsp_stream_id_i           completed stream tag
//   done_valid_o/done_stream_id_o  one-cycle retire pulse and tag
//   outstanding_o             issued-but-unanswered count
//   busy_o                    FIFO non-empty or requests in flight
//   err_o                     sticky protocol error, cleared by rst only
//
// state | meaning
// IDLE  | nothing presented; loads the FIFO head when one is issuable
// REQ   | req_* registers hold the head entry, waiting for req_ready_i
// STALL | head is blocked (id in flight or outstanding limit reached)
module vpu_req_issuer
   import vpu_pkg::*;
#(
   parameter int CMD_FIFO_DEPTH  = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic [INSTR_WIDTH-1:0]               cmd_instr_i,
   input  logic [STREAM_ID_WIDTH-1:0]           cmd_stream_id_i,
   output logic                                 req_valid_o,
   input  logic                                 req_ready_i,
   output logic [INSTR_WIDTH-1:0]               req_instr_o,
   output logic [STREAM_ID_WIDTH-1:0]           req_stream_id_o,
   input  logic                                 rsp_valid_i,
   output logic                                 rsp_ready_o,
   input  logic [STREAM_ID_WIDTH-1:0]           rsp_stream_id_i,
   output logic                                 done_valid_o,
   output logic [STREAM_ID_WIDTH-1:0]           done_stream_id_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 busy_o,
   output logic                                 err_o
);

   localparam int NUM_IDS = 2**STREAM_ID_WIDTH;
   localparam int OCW     = $clog2(MAX_OUTSTANDING+1);
   localparam int FCW     = $clog2(CMD_FIFO_DEPTH) + 1;

   vpu_issue_state_t             r_state, w_state_nxt;
   logic [INSTR_WIDTH-1:0]       r_req_instr, w_req_instr_nxt;
   logic [STREAM_ID_WIDTH-1:0]   r_req_id, w_req_id_nxt;
   logic [NUM_IDS-1:0]           r_inflight, w_inflight_nxt;
   logic [OCW-1:0]               r_outstanding, w_outstanding_nxt;
   logic                         r_done_valid;
   logic [STREAM_ID_WIDTH-1:0]   r_done_id;
   logic                         r_err;

   vpu_req_entry_t               w_entry_in, w_head, w_next;
   logic [FCW-1:0]               w_fifo_count;
   logic                         w_fifo_full, w_fifo_push, w_fifo_pop;
   logic                         w_issue, w_retire, w_stray, w_timeout;
   logic                         w_head_ok, w_next_ok;

   assign w_entry_in.instr     = cmd_instr_i;
   assign w_entry_in.stream_id = cmd_stream_id_i;
   assign w_fifo_push          = cmd_valid_i && cmd_ready_o;

   vpu_sync_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_fifo_push),
      .i_data  (w_entry_in),
      .i_pop   (w_fifo_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full)
   );

   assign w_issue  = (r_state == REQ) && req_ready_i;
   assign w_retire = rsp_valid_i && r_inflight[rsp_stream_id_i];
   assign w_stray  = rsp_valid_i && !r_inflight[rsp_stream_id_i];

   // Retire clears before issue sets, so a same-id pair leaves the bit set.
   always_comb begin
      w_inflight_nxt = r_inflight;
      if (w_retire) begin
         w_inflight_nxt[rsp_stream_id_i] = 1'b0;
      end
      if (w_issue) begin
         w_inflight_nxt[r_req_id] = 1'b1;
      end
   end

   always_comb begin
      case ({w_issue, w_retire})
         2'b10:   w_outstanding_nxt = r_outstanding + OCW'(1);
         2'b01:   w_outstanding_nxt = r_outstanding - OCW'(1);
         default: w_outstanding_nxt = r_outstanding;
      endcase
   end

   assign w_head_ok = (r_outstanding < OCW'(MAX_OUTSTANDING)) &&
                      !r_inflight[w_head.stream_id];
   // After a handshake the following entry is judged against the updated scoreboard.
   assign w_next_ok = (w_outstanding_nxt < OCW'(MAX_OUTSTANDING)) &&
                      !w_inflight_nxt[w_next.stream_id];

   always_comb begin
      w_state_nxt     = r_state;
      w_req_instr_nxt = r_req_instr;
      w_req_id_nxt    = r_req_id;
      w_fifo_pop      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fifo_count != '0) begin
               if (w_head_ok) begin
                  w_state_nxt     = REQ;
                  w_req_instr_nxt = w_head.instr;
                  w_req_id_nxt    = w_head.stream_id;
               end else begin
                  w_state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (w_head_ok) begin
               w_state_nxt     = REQ;
               w_req_instr_nxt = w_head.instr;
               w_req_id_nxt    = w_head.stream_id;
            end
         end
         REQ: begin
            if (req_ready_i) begin
               w_fifo_pop = 1'b1;
               if (w_fifo_count > FCW'(1)) begin
                  if (w_next_ok) begin
                     w_state_nxt     = REQ;
                     w_req_instr_nxt = w_next.instr;
                     w_req_id_nxt    = w_next.stream_id;
                  end else begin
                     w_state_nxt = STALL;
                  end
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef VPU_REQ_TIMEOUT_EN
   localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Down-counter from TIMEOUT_CYCLES-1; the step onto zero flags the timeout
   // and the counter then sits at zero until a response or drain reloads it.
   logic [WDW-1:0] r_wd_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt <= WDW'(TIMEOUT_CYCLES-1);
      end else if ((r_outstanding == '0) || w_retire) begin
         r_wd_cnt <= WDW'(TIMEOUT_CYCLES-1);
      end else if (r_wd_cnt != '0) begin
         r_wd_cnt <= r_wd_cnt - WDW'(1);
      end
   end

   assign w_timeout = (r_outstanding != '0) && !w_retire && (r_wd_cnt == WDW'(1));
`else
   // No watchdog in this build; the parameter only keeps the interface uniform.
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign w_timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_req_instr   <= '0;
         r_req_id      <= '0;
         r_inflight    <= '0;
         r_outstanding <= '0;
         r_done_valid  <= 1'b0;
         r_done_id     <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_req_instr   <= w_req_instr_nxt;
         r_req_id      <= w_req_id_nxt;
         r_inflight    <= w_inflight_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_done_valid  <= w_retire;
         if (w_retire) begin
            r_done_id <= rsp_stream_id_i;
         end
         r_err <= r_err | w_stray | w_timeout;
      end
   end

   assign cmd_ready_o      = !w_fifo_full;
   assign req_valid_o      = (r_state == REQ);
   assign req_instr_o      = r_req_instr;
   assign req_stream_id_o  = r_req_id;
   assign rsp_ready_o      = 1'b1;
   assign done_valid_o     = r_done_valid;
   assign done_stream_id_o = r_done_id;
   assign outstanding_o    = r_outstanding;
   assign busy_o           = (w_fifo_count != '0) || (r_outstanding != '0);
   assign err_o            = r_err;

endmodule

// File: tb/tb_vpu_req_issuer.sv
// Bench for vpu_req_issuer: a per-cycle vector table for the basic issue/retire
// and stray-response flow, hand-written sequences for limit, duplicate-id,
// back-pressure and watchdog cases, then random traffic against a
// queue/set reference model of the issuer's contract.
module tb_vpu_req_issuer;

   localparam int IW    = vpu_pkg::INSTR_WIDTH;
   localparam int SW    = vpu_pkg::STREAM_ID_WIDTH;
   localparam int NIDS  = 2**SW;
   localparam int DEPTH = 4;
   localparam int MAXO  = 4;
   localparam int TO    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid_i, cmd_ready_o;
   logic [IW-1:0] cmd_instr_i;
   logic [SW-1:0] cmd_stream_id_i;
   logic          req_valid_o, req_ready_i;
   logic [IW-1:0] req_instr_o;
   logic [SW-1:0] req_stream_id_o;
   logic          rsp_valid_i, rsp_ready_o;
   logic [SW-1:0] rsp_stream_id_i;
   logic          done_valid_o;
   logic [SW-1:0] done_stream_id_o;
   logic [2:0]    outstanding_o;
   logic          busy_o, err_o;

   vpu_req_issuer #(
      .CMD_FIFO_DEPTH  (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .cmd_instr_i      (cmd_instr_i),
      .cmd_stream_id_i  (cmd_stream_id_i),
      .req_valid_o      (req_valid_o),
      .req_ready_i      (req_ready_i),
      .req_instr_o      (req_instr_o),
      .req_stream_id_o  (req_stream_id_o),
      .rsp_valid_i      (rsp_valid_i),
      .rsp_ready_o      (rsp_ready_o),
      .rsp_stream_id_i  (rsp_stream_id_i),
      .done_valid_o     (done_valid_o),
      .done_stream_id_o (done_stream_id_o),
      .outstanding_o    (outstanding_o),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_iss    = 0;
   int n_done   = 0;

   always @(posedge clk) begin
      if (rst) begin
         n_iss  = 0;
         n_done = 0;
      end else begin
         if (req_valid_o && req_ready_i) n_iss = n_iss + 1;
         if (done_valid_o) n_done = n_done + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid_i     = 1'b0;
      cmd_instr_i     = '0;
      cmd_stream_id_i = '0;
      req_ready_i     = 1'b0;
      rsp_valid_i     = 1'b0;
      rsp_stream_id_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic [IW-1:0] instr_of(input int id);
      return 32'hC0DE_0000 | IW'(id);
   endfunction

   // ---------------- table vectors ----------------
   typedef struct {
      logic          cv;
      logic [SW-1:0] cid;
      logic          rr;
      logic          rv;
      logic [SW-1:0] rid;
      logic          e_rv;
      logic [SW-1:0] e_rid;
      logic          e_dv;
      logic [SW-1:0] e_did;
      logic [2:0]    e_out;
      logic          e_crdy;
      logic          e_err;
   } vec_t;

   function automatic vec_t mkv(int cv, int cid, int rr, int rv, int rid, int erv, int erid,
                                int edv, int edid, int eout, int ecr, int eerr);
      vec_t v;
      v.cv = cv[0];      v.cid = SW'(cid);   v.rr = rr[0];
      v.rv = rv[0];      v.rid = SW'(rid);
      v.e_rv = erv[0];   v.e_rid = SW'(erid);
      v.e_dv = edv[0];   v.e_did = SW'(edid);
      v.e_out = 3'(eout); v.e_crdy = ecr[0]; v.e_err = eerr[0];
      return v;
   endfunction

   vec_t tbl [11];

   // ---------------- reference model ----------------
   typedef struct {
      logic [SW-1:0] id;
      logic [IW-1:0] instr;
   } ent_t;

   ent_t          m_q [$];
   bit            m_infl [NIDS];
   int            m_cnt;
   bit            m_err;
   bit            m_dv;
   int            m_did;
   int            m_wd;
   bit            m_hold;
   logic [SW-1:0] m_hold_id;
   logic [IW-1:0] m_hold_instr;

   task automatic model_reset();
      m_q.delete();
      for (int k = 0; k < NIDS; k++) m_infl[k] = 1'b0;
      m_cnt  = 0;
      m_err  = 1'b0;
      m_dv   = 1'b0;
      m_did  = 0;
      m_wd   = TO - 1;
      m_hold = 1'b0;
   endtask

   task automatic rnd_cycle(input bit drain);
      int   ids [$];
      bit   iss, psh, ret, stray;
      ent_t e;
      cmd_valid_i     = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
      cmd_stream_id_i = SW'($urandom_range(0, NIDS-1));
      cmd_instr_i     = IW'($urandom);
      req_ready_i     = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
      rsp_valid_i     = 1'b0;
      rsp_stream_id_i = '0;
      for (int k = 0; k < NIDS; k++) if (m_infl[k]) ids.push_back(k);
      if (ids.size() > 0 && (drain || $urandom_range(0, 9) < 4)) begin
         rsp_valid_i     = 1'b1;
         rsp_stream_id_i = SW'(ids[$urandom_range(0, ids.size()-1)]);
      end

      chk("rnd_outstanding", outstanding_o, m_cnt);
      chk("rnd_done_valid", done_valid_o, m_dv);
      if (m_dv) chk("rnd_done_id", done_stream_id_o, m_did);
      chk("rnd_err", err_o, m_err);
      chk("rnd_cmd_ready", cmd_ready_o, m_q.size() < DEPTH);
      chk("rnd_busy", busy_o, (m_q.size() != 0) || (m_cnt != 0));
      if (m_hold) begin
         chk("rnd_hold_valid", req_valid_o, 1'b1);
         chk("rnd_hold_id", req_stream_id_o, m_hold_id);
         chk("rnd_hold_instr", req_instr_o, m_hold_instr);
      end
      if (req_valid_o) begin
         chk("rnd_req_has_cmd", m_q.size() > 0, 1'b1);
         if (m_q.size() > 0) begin
            chk("rnd_req_id", req_stream_id_o, m_q[0].id);
            chk("rnd_req_instr", req_instr_o, m_q[0].instr);
            chk("rnd_req_id_free", m_infl[m_q[0].id], 1'b0);
            chk("rnd_req_limit", m_cnt < MAXO, 1'b1);
         end
      end

      iss   = req_valid_o && req_ready_i && (m_q.size() > 0);
      psh   = cmd_valid_i && cmd_ready_o;
      ret   = rsp_valid_i && m_infl[rsp_stream_id_i];
      stray = rsp_valid_i && !m_infl[rsp_stream_id_i];
`ifdef VPU_REQ_TIMEOUT_EN
      if (m_cnt == 0 || ret) m_wd = TO - 1;
      else if (m_wd != 0) begin
         if (m_wd == 1) m_err = 1'b1;
         m_wd = m_wd - 1;
      end
`endif
      if (stray) m_err = 1'b1;
      m_dv = ret;
      if (ret) begin
         m_did = rsp_stream_id_i;
         m_infl[rsp_stream_id_i] = 1'b0;
         m_cnt = m_cnt - 1;
      end
      if (iss) begin
         e = m_q.pop_front();
         m_infl[e.id] = 1'b1;
         m_cnt = m_cnt + 1;
      end
      if (psh) begin
         e.id    = cmd_stream_id_i;
         e.instr = cmd_instr_i;
         m_q.push_back(e);
      end
      m_hold       = req_valid_o && !req_ready_i;
      m_hold_id    = req_stream_id_o;
      m_hold_instr = req_instr_o;
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bit            seen;
      bit            found;
      int            accepted;
      logic [SW-1:0] s_id;
      logic [IW-1:0] s_instr;

      //           cv cid rr rv rid erv erid edv edid eout ecr eerr
      tbl[0]  = mkv(1, 3, 1, 0, 0,  0, 0,   0, 0,   0,   1,  0);
      tbl[1]  = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   0,   1,  0);
      tbl[2]  = mkv(0, 0, 1, 0, 0,  1, 3,   0, 0,   0,   1,  0);
      tbl[3]  = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   1,   1,  0);
      tbl[4]  = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   1,   1,  0);
      tbl[5]  = mkv(0, 0, 1, 1, 3,  0, 0,   0, 0,   1,   1,  0);
      tbl[6]  = mkv(0, 0, 1, 0, 0,  0, 0,   1, 3,   0,   1,  0);
      tbl[7]  = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   0,   1,  0);
      tbl[8]  = mkv(0, 0, 1, 1, 5,  0, 0,   0, 0,   0,   1,  0);
      tbl[9]  = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   0,   1,  1);
      tbl[10] = mkv(0, 0, 1, 0, 0,  0, 0,   0, 0,   0,   1,  1);

      // reset values
      do_reset();
      chk("rst_cmd_ready", cmd_ready_o, 1'b1);
      chk("rst_rsp_ready", rsp_ready_o, 1'b1);
      chk("rst_req_valid", req_valid_o, 1'b0);
      chk("rst_req_id", req_stream_id_o, 0);
      chk("rst_req_instr", req_instr_o, 0);
      chk("rst_done_valid", done_valid_o, 1'b0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_err", err_o, 1'b0);

      // single issue/retire, then a stray response
      for (int i = 0; i < 11; i++) begin
         cmd_valid_i     = tbl[i].cv;
         cmd_stream_id_i = tbl[i].cid;
         cmd_instr_i     = instr_of(tbl[i].cid);
         req_ready_i     = tbl[i].rr;
         rsp_valid_i     = tbl[i].rv;
         rsp_stream_id_i = tbl[i].rid;
         chk($sformatf("vec%0d_req_valid", i), req_valid_o, tbl[i].e_rv);
         if (tbl[i].e_rv) begin
            chk($sformatf("vec%0d_req_id", i), req_stream_id_o, tbl[i].e_rid);
            chk($sformatf("vec%0d_req_instr", i), req_instr_o, instr_of(tbl[i].e_rid));
         end
         chk($sformatf("vec%0d_done_valid", i), done_valid_o, tbl[i].e_dv);
         if (tbl[i].e_dv) chk($sformatf("vec%0d_done_id", i), done_stream_id_o, tbl[i].e_did);
         chk($sformatf("vec%0d_outstanding", i), outstanding_o, tbl[i].e_out);
         chk($sformatf("vec%0d_cmd_ready", i), cmd_ready_o, tbl[i].e_crdy);
         chk($sformatf("vec%0d_err", i), err_o, tbl[i].e_err);
         cyc();
      end
      chk("stray_no_done", n_done, 1);
      do_reset();
      chk("err_cleared_by_rst", err_o, 1'b0);

      // outstanding limit: ids 0..4, fifth waits for a retire
      req_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_valid_i     = 1'b1;
         cmd_stream_id_i = SW'(i);
         cmd_instr_i     = instr_of(i);
         chk($sformatf("lim_push%0d_ready", i), cmd_ready_o, 1'b1);
         cyc();
      end
      cmd_valid_i = 1'b0;
      repeat (6) cyc();
      chk("lim_issued", n_iss, 4);
      chk("lim_outstanding", outstanding_o, 4);
      chk("lim_stalled", req_valid_o, 1'b0);
      chk("lim_busy", busy_o, 1'b1);
      rsp_valid_i     = 1'b1;
      rsp_stream_id_i = SW'(1);
      cyc();
      rsp_valid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (req_valid_o) found = 1'b1;
         else cyc();
      end
      chk("lim_resume_seen", found, 1'b1);
      chk("lim_resume_id", req_stream_id_o, 4);
      cyc();
      chk("lim_outstanding_after", outstanding_o, 4);
      chk("lim_issued_after", n_iss, 5);

      // duplicate stream id waits for its retire
      do_reset();
      req_ready_i     = 1'b1;
      cmd_valid_i     = 1'b1;
      cmd_stream_id_i = SW'(2);
      cmd_instr_i     = 32'h1111_0002;
      cyc();
      cmd_instr_i     = 32'h2222_0002;
      cyc();
      cmd_valid_i = 1'b0;
      repeat (6) cyc();
      chk("dup_issued", n_iss, 1);
      chk("dup_stalled", req_valid_o, 1'b0);
      chk("dup_outstanding", outstanding_o, 1);
      rsp_valid_i     = 1'b1;
      rsp_stream_id_i = SW'(2);
      cyc();
      rsp_valid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (req_valid_o) found = 1'b1;
         else cyc();
      end
      chk("dup_resume_seen", found, 1'b1);
      chk("dup_resume_id", req_stream_id_o, 2);
      chk("dup_resume_instr", req_instr_o, 32'h2222_0002);
      cyc();
      chk("dup_outstanding_after", outstanding_o, 1);
      chk("dup_issued_after", n_iss, 2);

      // back-pressure: request held stable, FIFO fills at 4
      do_reset();
      accepted = 0;
      seen     = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cmd_valid_i     = 1'b1;
         cmd_stream_id_i = SW'(accepted);
         cmd_instr_i     = instr_of(accepted);
         if (seen) begin
            chk("bp_valid_held", req_valid_o, 1'b1);
            chk("bp_id_held", req_stream_id_o, s_id);
            chk("bp_instr_held", req_instr_o, s_instr);
         end else if (req_valid_o) begin
            seen    = 1'b1;
            s_id    = req_stream_id_o;
            s_instr = req_instr_o;
         end
         if (cmd_ready_o) accepted++;
         cyc();
      end
      cmd_valid_i = 1'b0;
      chk("bp_accepted", accepted, 4);
      chk("bp_cmd_ready", cmd_ready_o, 1'b0);
      chk("bp_req_valid", req_valid_o, 1'b1);
      chk("bp_req_id", req_stream_id_o, 0);
      chk("bp_req_instr", req_instr_o, instr_of(0));
      chk("bp_issued", n_iss, 0);

      // watchdog
      do_reset();
      req_ready_i     = 1'b1;
      cmd_valid_i     = 1'b1;
      cmd_stream_id_i = SW'(1);
      cmd_instr_i     = instr_of(1);
      cyc();
      cmd_valid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (req_valid_o) found = 1'b1;
         else cyc();
      end
      chk("wd_issue_seen", found, 1'b1);
      repeat (15) cyc();
      chk("wd_err_before", err_o, 1'b0);
      cyc();
`ifdef VPU_REQ_TIMEOUT_EN
      chk("wd_err_at_16", err_o, 1'b1);
`else
      chk("wd_err_at_16", err_o, 1'b0);
      repeat (30) cyc();
      chk("wd_err_never", err_o, 1'b0);
`endif
      chk("wd_outstanding", outstanding_o, 1);

      // random traffic against the reference model
      do_reset();
      model_reset();
      for (int k = 0; k < 800; k++) rnd_cycle(1'b0);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         if (m_q.size() == 0 && m_cnt == 0 && !m_dv) found = 1'b1;
         else rnd_cycle(1'b1);
      end
      chk("rnd_drained", found, 1'b1);
      chk("rnd_idle_busy", busy_o, 1'b0);
      chk("rnd_idle_outstanding", outstanding_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
